// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//   Converts NUM_CH programmed intensities into per-channel binary spike trains.
//   Values are written over a valid/ready config port while idle; a start pulse
//   runs an encoding window of WINDOW active (ena=1) cycles, then done pulses.
//
//   Default encoding is first-order sigma-delta: each channel adds its value to
//   a VAL_W-bit accumulator every active cycle and spikes on the carry, so the
//   spike rate is value / 2^VAL_W.
//
//   Optional build macro STOCH_ENCODE_EN: a 16-bit Fibonacci LFSR
//   (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reloaded on every start) replaces
//   the accumulators; channel i spikes when the LFSR low byte rotated left by i
//   is below value_i.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        enable; low freezes a run (current forced to 0)
//   cfg_valid  config write request
//   cfg_ready  high only in IDLE
//   cfg_ch     channel index to write
//   cfg_value  intensity value to write
//   start      run request, sampled in IDLE
//   abort      synchronous run cancel, honoured in RUN
//   busy       high in RUN
//   done       one-cycle pulse after a completed run
//   current    registered spike bits, bit i = channel i
//   win_cnt    active cycles elapsed in the current or last run
module spike_rate_encoder #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned VAL_W  = 8,
  parameter int unsigned WINDOW = 256,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [VAL_W-1:0]  cfg_value,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] current,
  output logic [15:0]       win_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [15:0] WinEnd = 16'(WINDOW);

  state_e             state_q, state_d;
  logic [VAL_W-1:0]   val_q [NUM_CH];
  logic [VAL_W-1:0]   val_d [NUM_CH];
  logic [NUM_CH-1:0]  current_q, current_d;
  logic [15:0]        win_q, win_d;
  logic               ch_ok;

  // Writes to a channel index beyond NUM_CH are dropped.
  assign ch_ok = (32'(cfg_ch) < NUM_CH);

`ifdef STOCH_ENCODE_EN
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [VAL_W-1:0] rnd;
  logic [VAL_W-1:0] rot;

  assign rnd = lfsr_q[VAL_W-1:0];
`else
  logic [VAL_W-1:0] acc_q [NUM_CH];
  logic [VAL_W-1:0] acc_d [NUM_CH];
  logic [VAL_W:0]   sum;
`endif

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    current_d = '0;
    win_d     = win_q;
`ifdef STOCH_ENCODE_EN
    lfsr_d    = lfsr_q;
    rot       = '0;
`else
    acc_d     = acc_q;
    sum       = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (cfg_valid && ch_ok) begin
          val_d[cfg_ch] = cfg_value;
        end
        if (start) begin
          state_d = StRun;
          win_d   = '0;
`ifdef STOCH_ENCODE_EN
          lfsr_d  = LfsrSeed;
`else
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = '0;
          end
`endif
        end
      end

      StRun: begin
        if (abort) begin
          // Abort beats window completion; win_cnt keeps its value.
          state_d = StIdle;
        end else if (ena) begin
`ifdef STOCH_ENCODE_EN
          for (int i = 0; i < NUM_CH; i++) begin
            rot = VAL_W'((rnd << (i % VAL_W)) | (rnd >> ((VAL_W - (i % VAL_W)) % VAL_W)));
            current_d[i] = (rot < val_q[i]);
          end
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`else
          for (int i = 0; i < NUM_CH; i++) begin
            sum          = {1'b0, acc_q[i]} + {1'b0, val_q[i]};
            acc_d[i]     = sum[VAL_W-1:0];
            current_d[i] = sum[VAL_W];
          end
`endif
          win_d = win_q + 16'd1;
          // The spike registered on the completing edge is presented during
          // the DONE cycle, so a run shows exactly WINDOW accumulation results.
          if (win_d == WinEnd) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      current_q <= '0;
      win_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      current_q <= current_d;
      win_q     <= win_d;
      val_q     <= val_d;
    end
  end

`ifdef STOCH_ENCODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign current   = current_q;
  assign win_cnt   = win_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: stimulus pushes the expected
// per-channel spike counts of each completed run; a monitor counts spikes and
// pops/compares whenever done pulses.
module tb_spike_rate_encoder;

  localparam int NUM_CH = 8;
  localparam int VAL_W  = 8;
  localparam int WINDOW = 256;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [VAL_W-1:0]  cfg_value;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] current;
  logic [15:0]       win_cnt;

  spike_rate_encoder #(
    .NUM_CH (NUM_CH),
    .VAL_W  (VAL_W),
    .WINDOW (WINDOW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_value (cfg_value),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .current   (current),
    .win_cnt   (win_cnt)
  );

  typedef struct packed {
    logic [7:0][15:0] cnt;
    logic [15:0]      win;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   spk [NUM_CH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int c0, input int c1, input int c2, input int c3,
                          input int c4, input int c5, input int c6, input int c7);
    exp_t e;
    e.cnt[0] = 16'(c0); e.cnt[1] = 16'(c1); e.cnt[2] = 16'(c2); e.cnt[3] = 16'(c3);
    e.cnt[4] = 16'(c4); e.cnt[5] = 16'(c5); e.cnt[6] = 16'(c6); e.cnt[7] = 16'(c7);
    e.win    = 16'(WINDOW);
    exp_q.push_back(e);
  endtask

  // Monitor: spikes are counted over the RUN cycles plus the DONE cycle.
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !busy_prev) begin
        for (int i = 0; i < NUM_CH; i++) spk[i] = 0;
      end
      if (busy || done) begin
        for (int i = 0; i < NUM_CH; i++) spk[i] += int'(current[i]);
      end
      if (done) begin
        check("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("spikes_ch%0d", i), spk[i], int'(e.cnt[i]));
          end
          check("win_cnt_at_done", int'(win_cnt), int'(e.win));
        end
      end
      busy_prev = busy;
    end
  end

  task automatic cfg_write(input int ch, input int v);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_value = 8'(v);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic start_run();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts rising edges until done is visible; bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_arrived", int'(done), 1);
  endtask

`ifdef STOCH_ENCODE_EN
  function automatic int golden_ch0();
    logic [15:0] l;
    int n;
    l = 16'hACE1;
    n = 0;
    for (int k = 0; k < WINDOW; k++) begin
      if (l[7:0] < 8'd255) n++;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return n;
  endfunction
`endif

  initial begin
    int cyc;
    int g;
    logic [3:0] pat0;
    logic [3:0] pat2;
    logic [3:0] pat3;
    rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_value = '0;
    start = 1'b0; abort = 1'b0;
    #3;
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_current", int'(current), 0);
    check("rst_win_cnt", int'(win_cnt), 0);
    #9 rst_n = 1'b1;

`ifdef STOCH_ENCODE_EN
    cfg_write(0, 255);
    cfg_write(1, 0);
    g = golden_ch0();
    for (int r = 0; r < 2; r++) begin
      push_exp(g, 0, 0, 0, 0, 0, 0, 0);
      start_run();
      wait_done(cyc);
      check("stoch_run_len", cyc, WINDOW);
      @(posedge clk); #1;
    end
`else
    // Basic run: ch0=128, ch1=0, ch2=255, ch3=64.
    cfg_write(0, 128);
    cfg_write(1, 0);
    cfg_write(2, 255);
    cfg_write(3, 64);
    push_exp(128, 0, 255, 64, 0, 0, 0, 0);
    start_run();
    check("run_first_current", int'(current), 0);
    check("run_busy", int'(busy), 1);
    check("run_cfg_ready", int'(cfg_ready), 0);
    pat0 = 4'b1010; // bit k-1 = spike after k accumulations
    pat2 = 4'b1110;
    pat3 = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("pat_ch0_k%0d", k + 1), int'(current[0]), int'(pat0[k]));
      check($sformatf("pat_ch2_k%0d", k + 1), int'(current[2]), int'(pat2[k]));
      check($sformatf("pat_ch3_k%0d", k + 1), int'(current[3]), int'(pat3[k]));
    end
    wait_done(cyc);
    check("run1_len", cyc + 4, WINDOW);
    check("done_busy", int'(busy), 0);
    check("done_cfg_ready", int'(cfg_ready), 0);
    @(posedge clk); #1;
    check("after_done_pulse", int'(done), 0);
    check("after_done_ready", int'(cfg_ready), 1);
    check("after_done_win", int'(win_cnt), WINDOW);
    check("after_done_current", int'(current), 0);

    // ena low for 10 cycles mid-run.
    push_exp(128, 0, 255, 64, 0, 0, 0, 0);
    start_run();
    repeat (50) @(posedge clk);
    #1 ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("ena_low_current", int'(current), 0);
      check("ena_low_win", int'(win_cnt), 50);
    end
    ena = 1'b1;
    wait_done(cyc);
    check("ena_run_len", 50 + 10 + cyc, WINDOW + 10);
    @(posedge clk); #1;

    // cfg write and start on the same edge; cfg during RUN is refused.
    push_exp(128, 0, 255, 64, 0, 32, 0, 0);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_value = 8'd32; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_ch = 3'd6; cfg_value = 8'd200;
    check("run_cfg_refused", int'(cfg_ready), 0);
    repeat (3) @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_done(cyc);
    @(posedge clk); #1;

    // Abort at win_cnt=100, then restart (ch6 must still be 0).
    start_run();
    repeat (100) @(posedge clk);
    #1 check("abort_point_win", int'(win_cnt), 100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_current", int'(current), 0);
    check("abort_cfg_ready", int'(cfg_ready), 1);
    check("abort_win_held", int'(win_cnt), 100);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", int'(done), 0);
    end
    push_exp(128, 0, 255, 64, 0, 32, 0, 0);
    start_run();
    wait_done(cyc);
    check("restart_len", cyc, WINDOW);
    @(posedge clk); #1;

    // Asynchronous reset mid-run.
    start_run();
    repeat (50) @(posedge clk);
    #1 check("rst_point_win", int'(win_cnt), 50);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_current", int'(current), 0);
    check("async_rst_win", int'(win_cnt), 0);
    check("async_rst_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(0, 0, 0, 0, 0, 0, 0, 0);
    start_run();
    wait_done(cyc);
    check("post_rst_len", cyc, WINDOW);
`endif

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
